// File: rtl/uart_rx_typed_dechunker_pkg.sv
// Shared constants and types for the typed UART chunk framing.
// The tx chunker uses the same escape and end bytes.
package uart_rx_typed_dechunker_pkg;

  localparam logic [7:0] ESC_BYTE = 8'h00;
  localparam logic [7:0] EOC_BYTE = 8'h01;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_TYPE_ESC = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_DATA_ESC = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_RESYNC   = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_code_e;

  // Meaning of one accepted byte once escape context is resolved.
  typedef enum logic [2:0] {
    BC_NONE    = 3'd0,
    BC_ESC     = 3'd1,
    BC_LITERAL = 3'd2,
    BC_TYPE    = 3'd3,
    BC_END     = 3'd4,
    BC_RESYNC  = 3'd5
  } byte_class_e;

endpackage

// File: rtl/uart_rx_typed_dechunker_if.sv
// Byte-in / chunk-out bundle of the dechunker.
// The slave side is the dechunker; the master side feeds bytes and takes chunks.
interface uart_rx_typed_dechunker_if #(
  parameter int BUFFER_BYTE_SIZE  = 3,
  parameter int BUFFER_INDEX_SIZE = 32
);
  logic                            is_rx_done;
  logic [7:0]                      rx_data;
  logic                            chunk_ack;
  logic                            is_chunk_ready;
  logic [7:0]                      chunk_type;
  logic [BUFFER_INDEX_SIZE-1:0]    chunk_byte_size;
  logic [BUFFER_BYTE_SIZE*8-1:0]   chunk_bytes;
  logic                            is_chunk_error;
  logic [1:0]                      error_code;

  modport master (
    output is_rx_done, rx_data, chunk_ack,
    input  is_chunk_ready, chunk_type, chunk_byte_size, chunk_bytes,
           is_chunk_error, error_code
  );

  modport slave (
    input  is_rx_done, rx_data, chunk_ack,
    output is_chunk_ready, chunk_type, chunk_byte_size, chunk_bytes,
           is_chunk_error, error_code
  );
endinterface

// File: rtl/uart_rx_escape_decoder.sv
// Resolves the 0x00 escape prefix and classifies each accepted byte.
// in_chunk_i selects payload meaning (literal/end/resync) versus type meaning.
module uart_rx_escape_decoder
  import uart_rx_typed_dechunker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        in_chunk_i,
  input  logic [7:0]  byte_i,
  output byte_class_e class_o
);

  logic pending_q, pending_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    class_o   = BC_NONE;
    pending_d = pending_q;
    if (valid_i) begin
      if (!pending_q) begin
        if (byte_i == ESC_BYTE) begin
          class_o   = BC_ESC;
          pending_d = 1'b1;
        end else begin
          class_o = BC_LITERAL;
        end
      end else if (in_chunk_i) begin
        pending_d = 1'b0;
        if (byte_i == ESC_BYTE)      class_o = BC_LITERAL;
        else if (byte_i == EOC_BYTE) class_o = BC_END;
        else                         class_o = BC_RESYNC;
      end else if (byte_i == ESC_BYTE) begin
        // Repeated 0x00 before a type byte keeps the escape open.
        class_o = BC_ESC;
      end else begin
        class_o   = BC_TYPE;
        pending_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/uart_rx_typed_dechunker.sv
// Reassembles escaped, typed chunks from a UART byte stream and holds each
// complete chunk on registered outputs until the consumer acknowledges it.
module uart_rx_typed_dechunker
  import uart_rx_typed_dechunker_pkg::*;
#(
  parameter int BUFFER_BYTE_SIZE  = 3,
  parameter int BUFFER_INDEX_SIZE = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  uart_rx_typed_dechunker_if.slave bus
);

  localparam logic [BUFFER_INDEX_SIZE-1:0] CAPACITY = BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE);

  state_e                         state_q, state_d;
  logic                           ready_q, ready_d;
  logic                           err_q, err_d;
  err_code_e                      code_q, code_d;
  logic [7:0]                     type_q, type_d;
  logic [BUFFER_INDEX_SIZE-1:0]   size_q, size_d;
  logic [BUFFER_BYTE_SIZE*8-1:0]  bytes_q, bytes_d;
  logic [BUFFER_INDEX_SIZE-1:0]   count_q, count_d;

  logic        accept;
  logic        in_chunk;
  byte_class_e byte_class;

  // A held chunk blocks new bytes unless the ack arrives in the same cycle.
  assign accept   = bus.is_rx_done && (state_q != ST_HOLD || bus.chunk_ack);
  assign in_chunk = (state_q == ST_PAYLOAD) || (state_q == ST_DATA_ESC);

  uart_rx_escape_decoder u_escape_decoder (
    .clk        (CLK),
    .rst        (RST),
    .valid_i    (accept),
    .in_chunk_i (in_chunk),
    .byte_i     (bus.rx_data),
    .class_o    (byte_class)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    code_d  = code_q;
    type_d  = type_q;
    size_d  = size_q;
    bytes_d = bytes_q;
    count_d = count_q;

    unique case (state_q)
      ST_HUNT: begin
        if (byte_class == BC_ESC) state_d = ST_TYPE_ESC;
      end

      ST_TYPE_ESC: begin
        if (byte_class == BC_TYPE) begin
          type_d  = bus.rx_data;
          count_d = '0;
          state_d = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD, ST_DATA_ESC: begin
        case (byte_class)
          BC_ESC: state_d = ST_DATA_ESC;
          BC_LITERAL: begin
            if (count_q >= CAPACITY) begin
              err_d   = 1'b1;
              code_d  = ERR_OVERFLOW;
              count_d = '0;
              state_d = ST_HUNT;
            end else begin
              for (int i = 0; i < BUFFER_BYTE_SIZE; i++) begin
                if (count_q == BUFFER_INDEX_SIZE'(i)) bytes_d[i*8 +: 8] = bus.rx_data;
              end
              count_d = count_q + BUFFER_INDEX_SIZE'(1);
              state_d = ST_PAYLOAD;
            end
          end
          BC_END: begin
            size_d  = count_q;
            ready_d = 1'b1;
            state_d = ST_HOLD;
          end
          BC_RESYNC: begin
            // The offending byte starts a fresh chunk as its type.
            err_d   = 1'b1;
            code_d  = ERR_RESYNC;
            type_d  = bus.rx_data;
            count_d = '0;
            state_d = ST_PAYLOAD;
          end
          default: ;
        endcase
      end

      ST_HOLD: begin
        if (bus.chunk_ack) begin
          ready_d = 1'b0;
          state_d = (byte_class == BC_ESC) ? ST_TYPE_ESC : ST_HUNT;
        end else if (bus.is_rx_done) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_HUNT;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      type_q  <= '0;
      size_q  <= '0;
      // NOTE: the payload buffer drives chunk_bytes directly, so it is reset like any output register.
      bytes_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      code_q  <= code_d;
      type_q  <= type_d;
      size_q  <= size_d;
      bytes_q <= bytes_d;
      count_q <= count_d;
    end
  end

  assign bus.is_chunk_ready  = ready_q;
  assign bus.is_chunk_error  = err_q;
  assign bus.error_code      = code_q;
  assign bus.chunk_type      = type_q;
  assign bus.chunk_byte_size = size_q;
  assign bus.chunk_bytes     = bytes_q;

endmodule

// File: tb/tb_uart_rx_typed_dechunker.sv
// Directed bench for uart_rx_typed_dechunker with hand-computed expectations.
module tb_uart_rx_typed_dechunker;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  uart_rx_typed_dechunker_if #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32)) bus ();

  uart_rx_typed_dechunker #(.BUFFER_BYTE_SIZE(3), .BUFFER_INDEX_SIZE(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns 1 time unit after the edge that captured it.
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    bus.is_rx_done = 1'b1;
    bus.rx_data    = b;
    @(posedge CLK);
    #1;
    bus.is_rx_done = 1'b0;
  endtask

  task automatic send_ack();
    bus.chunk_ack = 1'b1;
    @(posedge CLK);
    #1;
    bus.chunk_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.is_rx_done = 1'b0;
    bus.rx_data    = 8'h00;
    bus.chunk_ack  = 1'b0;
    RST = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("rst_ready", 64'(bus.is_chunk_ready), 64'd0);
    check("rst_err",   64'(bus.is_chunk_error), 64'd0);
    check("rst_code",  64'(bus.error_code), 64'd0);
    check("rst_type",  64'(bus.chunk_type), 64'd0);
    check("rst_size",  64'(bus.chunk_byte_size), 64'd0);
    check("rst_bytes", 64'(bus.chunk_bytes), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Full 3-byte chunk
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h41);
    send_byte(8'h42); send_byte(8'h43); send_byte(8'h00);
    check("c1_not_ready_early", 64'(bus.is_chunk_ready), 64'd0);
    send_byte(8'h01);
    check("c1_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("c1_type",  64'(bus.chunk_type), 64'h05);
    check("c1_size",  64'(bus.chunk_byte_size), 64'd3);
    check("c1_bytes", 64'(bus.chunk_bytes), 64'h434241);
    send_ack();
    check("c1_ack_drops_ready", 64'(bus.is_chunk_ready), 64'd0);

    // Escaped literal zero in payload
    send_byte(8'h00); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h09); send_byte(8'h00); send_byte(8'h01);
    check("c2_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("c2_type",  64'(bus.chunk_type), 64'h07);
    check("c2_size",  64'(bus.chunk_byte_size), 64'd2);
    check("c2_bytes_lo", 64'(bus.chunk_bytes[15:0]), 64'h0900);
    send_ack();

    // Overflow on the fourth payload byte
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33);
    check("ovf_no_err_at_cap", 64'(bus.is_chunk_error), 64'd0);
    send_byte(8'h44);
    check("ovf_err",   64'(bus.is_chunk_error), 64'd1);
    check("ovf_code",  64'(bus.error_code), 64'd1);
    check("ovf_ready", 64'(bus.is_chunk_ready), 64'd0);
    next_cycle();
    check("ovf_err_one_cycle", 64'(bus.is_chunk_error), 64'd0);
    // From HUNT, 00 01 opens a chunk of type 0x01 rather than ending one
    send_byte(8'h00); send_byte(8'h01);
    check("ovf_hunt_no_chunk", 64'(bus.is_chunk_ready), 64'd0);
    send_byte(8'h00); send_byte(8'h01);
    check("ovf_empty_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("ovf_empty_type",  64'(bus.chunk_type), 64'h01);
    check("ovf_empty_size",  64'(bus.chunk_byte_size), 64'd0);
    send_ack();

    // Resync: 00 08 mid-chunk restarts with type 0x08
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h11);
    send_byte(8'h00); send_byte(8'h08);
    check("rs_err",  64'(bus.is_chunk_error), 64'd1);
    check("rs_code", 64'(bus.error_code), 64'd2);
    send_byte(8'h22); send_byte(8'h00); send_byte(8'h01);
    check("rs_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("rs_type",  64'(bus.chunk_type), 64'h08);
    check("rs_size",  64'(bus.chunk_byte_size), 64'd1);
    check("rs_byte0", 64'(bus.chunk_bytes[7:0]), 64'h22);

    // Overrun while holding
    send_byte(8'h55);
    check("orun_err",   64'(bus.is_chunk_error), 64'd1);
    check("orun_code",  64'(bus.error_code), 64'd3);
    check("orun_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("orun_type",  64'(bus.chunk_type), 64'h08);
    check("orun_size",  64'(bus.chunk_byte_size), 64'd1);
    check("orun_byte0", 64'(bus.chunk_bytes[7:0]), 64'h22);
    next_cycle();
    check("orun_err_one_cycle", 64'(bus.is_chunk_error), 64'd0);

    // Ack coinciding with a 0x00 strobe: byte handled as in HUNT
    bus.chunk_ack  = 1'b1;
    bus.is_rx_done = 1'b1;
    bus.rx_data    = 8'h00;
    next_cycle();
    bus.chunk_ack  = 1'b0;
    bus.is_rx_done = 1'b0;
    check("co_ready_dropped", 64'(bus.is_chunk_ready), 64'd0);
    check("co_no_err", 64'(bus.is_chunk_error), 64'd0);
    send_byte(8'h0B); send_byte(8'h00); send_byte(8'h01);
    check("co_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("co_type",  64'(bus.chunk_type), 64'h0B);
    check("co_size",  64'(bus.chunk_byte_size), 64'd0);
    send_ack();

    // Ack outside HOLD has no effect
    send_ack();
    send_byte(8'h00); send_byte(8'h0C); send_byte(8'h77);
    bus.chunk_ack = 1'b1;
    next_cycle();
    bus.chunk_ack = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    check("ign_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("ign_type",  64'(bus.chunk_type), 64'h0C);
    check("ign_size",  64'(bus.chunk_byte_size), 64'd1);
    check("ign_byte0", 64'(bus.chunk_bytes[7:0]), 64'h77);
    send_ack();

    // Reset mid-chunk clears everything without an error pulse
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h41);
    #2 RST = 1'b1;
    #1;
    check("mrst_ready", 64'(bus.is_chunk_ready), 64'd0);
    check("mrst_err",   64'(bus.is_chunk_error), 64'd0);
    check("mrst_code",  64'(bus.error_code), 64'd0);
    check("mrst_type",  64'(bus.chunk_type), 64'd0);
    check("mrst_size",  64'(bus.chunk_byte_size), 64'd0);
    check("mrst_bytes", 64'(bus.chunk_bytes), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    send_byte(8'h00); send_byte(8'h06); send_byte(8'h00); send_byte(8'h01);
    check("prst_ready", 64'(bus.is_chunk_ready), 64'd1);
    check("prst_type",  64'(bus.chunk_type), 64'h06);
    check("prst_size",  64'(bus.chunk_byte_size), 64'd0);
    check("prst_no_err", 64'(bus.is_chunk_error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
